// File: rtl/mem_rr_arbiter_if.sv
// Bundle of the per-core look-ahead request lanes, their completions, and the
// single downstream memory/IO transaction port shared by the cores.
interface mem_rr_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int ID_BITS = (N_CORES > 1) ? $clog2(N_CORES) : 1
);
  logic [N_CORES-1:0]    cpu_la_read;
  logic [N_CORES-1:0]    cpu_la_write;
  logic [32*N_CORES-1:0] cpu_la_addr;
  logic [32*N_CORES-1:0] cpu_la_wdata;
  logic [4*N_CORES-1:0]  cpu_la_wstrb;
  logic [N_CORES-1:0]    cpu_ready;
  logic [32*N_CORES-1:0] cpu_rdata;
  logic                  mem_valid;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [ID_BITS-1:0]    mem_id;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  logic                  proto_err;

  // The arbiter itself sits on the slave side of this bundle.
  modport slave (
    input  cpu_la_read, cpu_la_write, cpu_la_addr, cpu_la_wdata, cpu_la_wstrb,
    input  mem_ready, mem_rdata,
    output cpu_ready, cpu_rdata, mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_wstrb, mem_id, proto_err
  );

  modport master (
    output cpu_la_read, cpu_la_write, cpu_la_addr, cpu_la_wdata, cpu_la_wstrb,
    output mem_ready, mem_rdata,
    input  cpu_ready, cpu_rdata, mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_wstrb, mem_id, proto_err
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory/IO target among N picorv32 cores;
// each core's look-ahead request is latched into a slot and served in turn.
module mem_rr_arbiter #(
  parameter int N_CORES = 4,
  parameter int ID_BITS = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  mem_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [N_CORES-1:0] pending, req, accept, done_mask;
  logic               slot_we    [N_CORES];
  logic [31:0]        slot_addr  [N_CORES];
  logic [31:0]        slot_wdata [N_CORES];
  logic [3:0]         slot_wstrb [N_CORES];
  logic [ID_BITS-1:0] rr_ptr, sel, mem_id;
  logic               sel_found, grant, complete;

  logic                  mem_valid, mem_we, proto_err;
  logic [31:0]           mem_addr, mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [N_CORES-1:0]    cpu_ready;
  logic [32*N_CORES-1:0] cpu_rdata;

  function automatic logic [ID_BITS-1:0] wrap_add(logic [ID_BITS-1:0] base, int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_CORES) sum = sum - N_CORES;
    return sum[ID_BITS-1:0];
  endfunction

  // A pending slot (or the granted one, which is still pending) cannot be overwritten.
  assign req    = bus.cpu_la_read | bus.cpu_la_write;
  assign accept = req & ~pending;

  // Scan from the far end back toward rr_ptr so the nearest pending core wins.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (pending[wrap_add(rr_ptr, i)]) begin
        sel       = wrap_add(rr_ptr, i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: if (sel_found) begin
        grant      = 1'b1;
        state_next = BUSY;
      end
      BUSY: if (mem_valid && bus.mem_ready) begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign done_mask = complete ? (N_CORES'(1) << mem_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (reset) begin
        slot_we[i]    <= 1'b0;
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        slot_wstrb[i] <= '0;
      end else if (accept[i]) begin
        slot_we[i]    <= bus.cpu_la_write[i];
        slot_addr[i]  <= bus.cpu_la_addr[32*i +: 32];
        slot_wdata[i] <= bus.cpu_la_wdata[32*i +: 32];
        slot_wstrb[i] <= bus.cpu_la_write[i] ? bus.cpu_la_wstrb[4*i +: 4] : 4'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      rr_ptr    <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_id    <= '0;
      cpu_ready <= '0;
      cpu_rdata <= '0;
      proto_err <= 1'b0;
    end else begin
      pending   <= (pending & ~done_mask) | accept;
      cpu_ready <= done_mask;
      proto_err <= proto_err | (|(req & pending)) | (|(bus.cpu_la_read & bus.cpu_la_write));
      if (grant) begin
        mem_valid <= 1'b1;
        mem_id    <= sel;
        mem_we    <= slot_we[sel];
        mem_addr  <= slot_addr[sel];
        mem_wdata <= slot_wdata[sel];
        mem_wstrb <= slot_wstrb[sel];
      end
      if (complete) begin
        mem_valid <= 1'b0;
        rr_ptr    <= (mem_id == ID_BITS'(N_CORES - 1)) ? '0 : mem_id + 1'b1;
        if (!mem_we) cpu_rdata[32*mem_id +: 32] <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_valid = mem_valid;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wstrb = mem_wstrb;
  assign bus.mem_id    = mem_id;
  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.proto_err = proto_err;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a vector table of single transactions
// followed by hand-written multi-cycle sequences for arbitration corner cases.
module tb_mem_rr_arbiter;

  localparam int N_CORES = 4;
  localparam int ID_BITS = 2;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  mem_rr_arbiter_if #(.N_CORES(N_CORES), .ID_BITS(ID_BITS)) bus ();

  mem_rr_arbiter #(.N_CORES(N_CORES), .ID_BITS(ID_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata_in;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int core, input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.cpu_la_read                 = '0;
    bus.cpu_la_write                = '0;
    bus.cpu_la_read[core]           = rd;
    bus.cpu_la_write[core]          = wr;
    bus.cpu_la_addr[32*core +: 32]  = addr;
    bus.cpu_la_wdata[32*core +: 32] = wdata;
    bus.cpu_la_wstrb[4*core +: 4]   = wstrb;
  endtask

  task automatic clearStrobes();
    bus.cpu_la_read  = '0;
    bus.cpu_la_write = '0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearStrobes();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [127:0] memFields();
    return {56'b0, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_id};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.cpu_la_read  = '0;
    bus.cpu_la_write = '0;
    bus.cpu_la_addr  = '0;
    bus.cpu_la_wdata = '0;
    bus.cpu_la_wstrb = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = '0;

    vecs[0] = '{2, 1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b0, 1'b1, 32'h1000_0000, 32'h0100_0001, 4'hF, 32'h1111_1111, 1'b1, 4'hF, 32'h0};
    vecs[2] = '{3, 1'b1, 1'b0, 32'h2000_0008, 32'h0000_0055, 4'hA, 32'hCAFE_F00D, 1'b0, 4'h0, 32'hCAFE_F00D};
    vecs[3] = '{2, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 4'h3, 32'h2222_2222, 1'b1, 4'h3, 32'hDEAD_BEEF};
    vecs[4] = '{0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0, 4'h0, 32'hA5A5_5A5A};
    vecs[5] = '{2, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'h0, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000};

    tick();
    tick();
    checkOutput("reset mem fields", memFields(), 128'h0);
    checkOutput("reset ready/err", {bus.cpu_ready, bus.proto_err}, 128'h0);
    checkOutput("reset rdata", bus.cpu_rdata, 128'h0);
    reset = 1'b0;

    // Single transactions with downstream always ready.
    bus.mem_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      bus.mem_rdata = vecs[v].rdata_in;
      applyStimulus(vecs[v].core, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
      tick();
      clearStrobes();
      tick();
      checkOutput($sformatf("vec%0d grant", v), memFields(),
                  {56'b0, 1'b1, vecs[v].exp_we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_wstrb,
                   ID_BITS'(vecs[v].core)});
      tick();
      checkOutput($sformatf("vec%0d ready", v), {bus.cpu_ready, bus.mem_valid},
                  {N_CORES'(1) << vecs[v].core, 1'b0});
      checkOutput($sformatf("vec%0d rdata", v), bus.cpu_rdata[32*vecs[v].core +: 32], vecs[v].exp_rdata);
    end

    // Round robin: all four cores request at once.
    doReset();
    bus.mem_ready = 1'b1;
    for (int c = 0; c < N_CORES; c++) bus.cpu_la_addr[32*c +: 32] = 32'h100 * c;
    bus.cpu_la_read = 4'hF;
    tick();
    clearStrobes();
    tick();
    for (int k = 0; k < N_CORES; k++) begin
      checkOutput($sformatf("rr grant %0d", k), {bus.mem_valid, bus.mem_id}, {1'b1, ID_BITS'(k)});
      bus.mem_rdata = 32'h5000_0000 | k;
      tick();
      checkOutput($sformatf("rr ready %0d", k), bus.cpu_ready, N_CORES'(1) << k);
      checkOutput($sformatf("rr rdata %0d", k), bus.cpu_rdata[32*k +: 32], 32'h5000_0000 | k);
      if (k < N_CORES - 1) tick();
    end
    bus.cpu_la_read = 4'b1001;
    tick();
    clearStrobes();
    tick();
    checkOutput("rr rerequest first", {bus.mem_valid, bus.mem_id}, {1'b1, 2'd0});
    tick();
    tick();
    checkOutput("rr rerequest second", {bus.mem_valid, bus.mem_id}, {1'b1, 2'd3});
    tick();
    checkOutput("rr no proto_err", bus.proto_err, 1'b0);

    // Stalled downstream write from core 1; core 0 requests mid-stall.
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h7777_0000;
    applyStimulus(1, 1'b0, 1'b1, 32'h1000_0000, 32'h0100_0001, 4'hF);
    tick();
    clearStrobes();
    tick();
    for (int s = 0; s < 6; s++) begin
      checkOutput($sformatf("stall hold %0d", s), memFields(),
                  {56'b0, 1'b1, 1'b1, 32'h1000_0000, 32'h0100_0001, 4'hF, 2'd1});
      checkOutput($sformatf("stall no ready %0d", s), bus.cpu_ready, 128'h0);
      if (s == 1) applyStimulus(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
      if (s == 2) clearStrobes();
      if (s == 5) bus.mem_ready = 1'b1;
      tick();
    end
    checkOutput("stall ready pulse", {bus.cpu_ready, bus.mem_valid}, {4'b0010, 1'b0});
    checkOutput("stall rdata kept", bus.cpu_rdata[63:32], 32'h5000_0001);
    tick();
    checkOutput("stall next grant", memFields(),
                {56'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 2'd0});
    checkOutput("stall ready single", bus.cpu_ready, 128'h0);
    tick();
    checkOutput("stall core0 ready", bus.cpu_ready, 4'b0001);
    checkOutput("stall core0 rdata", bus.cpu_rdata[31:0], 32'h7777_0000);

    // Back-to-back: core 0 re-strobes in its own cpu_ready cycle.
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
    tick();
    clearStrobes();
    tick();
    tick();
    checkOutput("b2b first ready", bus.cpu_ready, 4'b0001);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0084, 32'h0, 4'h0);
    tick();
    clearStrobes();
    tick();
    checkOutput("b2b second grant", {bus.mem_valid, bus.mem_id, bus.mem_addr}, {1'b1, 2'd0, 32'h0000_0084});
    tick();
    checkOutput("b2b second ready", bus.cpu_ready, 4'b0001);
    checkOutput("b2b no proto_err", bus.proto_err, 1'b0);

    // Protocol error: core 3 re-strobes while pending.
    applyStimulus(3, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    tick();
    applyStimulus(3, 1'b1, 1'b0, 32'h0000_03FF, 32'h0, 4'h0);
    tick();
    clearStrobes();
    checkOutput("perr original addr", {bus.mem_valid, bus.mem_id, bus.mem_addr}, {1'b1, 2'd3, 32'h0000_0300});
    checkOutput("perr flag set", bus.proto_err, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("perr no regrant", bus.mem_valid, 1'b0);
    checkOutput("perr sticky", bus.proto_err, 1'b1);

    // Reset while a transaction is stalled in BUSY.
    bus.mem_ready = 1'b0;
    applyStimulus(2, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    tick();
    clearStrobes();
    tick();
    checkOutput("rst busy valid", bus.mem_valid, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0500, 32'h1, 4'h1);
    tick();
    clearStrobes();
    reset = 1'b1;
    tick();
    checkOutput("rst abandon", {bus.mem_valid, bus.cpu_ready, bus.proto_err}, 128'h0);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("rst pending cleared", {bus.mem_valid, bus.cpu_ready}, 128'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    tick();
    clearStrobes();
    tick();
    checkOutput("rst fresh grant", {bus.mem_valid, bus.mem_id, bus.mem_addr}, {1'b1, 2'd0, 32'h0000_0010});
    tick();
    checkOutput("rst fresh ready", bus.cpu_ready, 4'b0001);

    // Read and write together on core 1 count as a write plus a protocol error.
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_0600, 32'hABCD_0000, 4'hC);
    tick();
    clearStrobes();
    tick();
    checkOutput("rdwr as write", {bus.mem_we, bus.mem_wstrb, bus.mem_id}, {1'b1, 4'hC, 2'd1});
    checkOutput("rdwr proto_err", bus.proto_err, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one single-port memory/IO target between N_CORES picorv32 look-ahead memory interfaces.
- Latches each core's mem_la_* request into a per-core slot.
- Grants one slot at a time with rotating (round-robin) priority and holds a valid/ready transaction to the downstream memory/IO decoder.
- Routes read data and a one-cycle ready pulse back to the requesting core. It sits between the core array and the memory/UART/LED decode logic in soc.

Parameters:
N_CORES, 4, number of requesting cores (2..8, need not be a power of two)
ID_BITS, $clog2(N_CORES) (min 1), width of the granted-core index

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
cpu_la_read  in  N_CORES  per-core look-ahead read strobe (one-cycle pulse)
cpu_la_write  in  N_CORES  per-core look-ahead write strobe (one-cycle pulse)
cpu_la_addr  in  32*N_CORES  core i in bits [32*i+31 -: 32]
cpu_la_wdata  in  32*N_CORES  core i in bits [32*i+31 -: 32]
cpu_la_wstrb  in  4*N_CORES  core i in bits [4*i+3 -: 4]
cpu_ready  out  N_CORES  one-cycle completion pulse per core
cpu_rdata  out  32*N_CORES  per-core read data, valid when cpu_ready[i]=1
mem_valid  out  1  downstream transaction valid
mem_we  out  1  1=write, 0=read
mem_addr  out  32  transaction address
mem_wdata  out  32  write data
mem_wstrb  out  4  byte enables (0 for reads)
mem_id  out  ID_BITS  index of granted core
mem_ready  in  1  downstream completion; may be high in the first mem_valid cycle
mem_rdata  in  32  read data, sampled when mem_valid&&mem_ready&&!mem_we
proto_err  out  1  sticky protocol-violation flag

Behaviour:

Reset:
- All outputs are 0.
- pending[] = 0, rr_ptr = 0, state = IDLE.
- Reset asserted mid-transaction abandons it: mem_valid = 0 from the next cycle, no cpu_ready is issued, and slot contents are discarded.

Capture:
- On a clock edge with cpu_la_read[i] | cpu_la_write[i]:
  - slot i <= {we, addr, wdata, wstrb}; a read forces wstrb = 0.
  - pending[i] <= 1.
- Read and write asserted together are treated as a write and set proto_err.
- A request for core i while pending[i] = 1, or while core i is granted, is ignored (slot unchanged) and sets proto_err.
- proto_err clears only on reset.

Arbitration FSM:
- IDLE:
  - If any pending bit is set, select the first set index scanning rr_ptr, rr_ptr+1, … wrapping from N_CORES-1 to 0.
  - Edge actions: mem_id <= sel; mem_valid <= 1; mem_we/addr/wdata/wstrb <= slot[sel]; state <= BUSY.
  - A request captured on the same edge is not eligible until the following cycle.
- BUSY:
  - mem_* outputs are held stable while mem_ready = 0 (no timeout).
  - On mem_valid && mem_ready, edge actions:
    - mem_valid <= 0.
    - pending[mem_id] <= 0.
    - cpu_ready[mem_id] <= 1 for exactly one cycle.
    - If read: cpu_rdata[mem_id] <= mem_rdata. Other cores' rdata fields and write completions leave rdata unchanged.
    - rr_ptr <= (mem_id == N_CORES-1) ? 0 : mem_id+1.
    - state <= IDLE.
- cpu_ready is 0 on all other cycles.

Timing:
- Minimum latency: la strobe at cycle t → pending at t+1 → mem_valid at t+2 → (mem_ready at t+2) → cpu_ready at t+3.
- Peak throughput is one transaction per 2 cycles.

Fairness and corner cases:
- A pending core waits for at most N_CORES-1 other grants.
- A core may issue its next la strobe in the same cycle its cpu_ready is high. This is legal: pending was already cleared, so the request is captured normally with no proto_err.
- cpu_rdata fields retain their last value between accesses.

Test Plan:
1. Single read: core 2 la_read addr 0x0000_0104, mem_ready tied 1, mem_rdata 0xDEADBEEF → mem_valid=1 with mem_id=2, mem_we=0, mem_wstrb=0 at t+2; cpu_ready=4'b0100 at t+3; cpu_rdata[95:64]=0xDEADBEEF.
2. Round-robin: all 4 cores strobe in the same cycle after reset, mem_ready=1 → grant order 0,1,2,3, one cpu_ready pulse per core on cycles t+3, t+5, t+7, t+9. Then cores 0 and 3 re-request → 0 is granted before 3 (rr_ptr=0 after core 3).
3. Stalled downstream: core 1 write addr 0x1000_0000, wdata 0x0100_0001, wstrb 4'hF, mem_ready low 5 cycles then high → mem_* fields stable all 6 cycles; cpu_ready[1] is a single pulse; cpu_rdata unchanged; core 0 requesting mid-stall is granted next.
4. Back-to-back same core: core 0 issues a new la_read in the cycle cpu_ready[0]=1 → captured, served 2 cycles later, proto_err stays 0.
5. Protocol error: core 3 re-strobes while pending → slot unchanged (original addr issued) and proto_err=1 until reset.
6. Reset mid-BUSY: assert reset while mem_valid=1 and mem_ready=0 → next cycle mem_valid=0, cpu_ready=0, pending=0. After release, a fresh core 0 request is granted first.
